// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared types and helpers for the sprite ROM arbiter.
// Holds the default ROM geometry, layer names, collision FSM states and the priority encoder.
package sprite_pkg;

    localparam int SPR_ADDR_W = 21;
    localparam int SPR_DATA_W = 4;
    // Widest request vector the priority encoder accepts
    localparam int PRIO_MAX_W = 32;

    typedef enum logic [1:0] {
        LAYER_PLAYER = 2'd0,
        LAYER_ENEMY0 = 2'd1,
        LAYER_ENEMY1 = 2'd2,
        LAYER_BULLET = 2'd3
    } layer_t;

    typedef enum logic {
        RUN   = 1'b0,
        LATCH = 1'b1
    } coll_state_t;

    // Lowest set index wins; an all-zero vector returns 0 (caller qualifies with |req)
    function automatic int unsigned prio_enc(input logic [PRIO_MAX_W-1:0] i_req);
        int unsigned idx;
        idx = 0;
        for (int i = PRIO_MAX_W - 1; i >= 0; i--) begin
            if (i_req[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_pipe_delay.sv
// Resettable shift register that carries side-band pixel fields
// alongside the ROM read so they line up with the returned data.
module sprite_pipe_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             frame_Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift one stage per pixel clock; reset flushes every stage
    always_ff @(posedge frame_Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM arbiter: grants the single ROM address port to the highest-priority
// sprite engine covering the current pixel, aligns layer/coordinates with the ROM
// return, and latches a per-frame player-overlap flag.
// Optional build macro SPRITE_ARB_KEY_EN: pixels whose ROM data equals TRANSP are
// reported as not valid so the background shows through.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = SPR_ADDR_W,
    parameter int DATA_W  = SPR_DATA_W,
    parameter int ROM_LAT = 2,
    parameter logic [DATA_W-1:0] TRANSP = '0,
    localparam int LAYER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      frame_Clk,
    input  logic                      Reset,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic [NUM_REQ-1:0]        req_on,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic                      pix_valid,
    output logic [LAYER_W-1:0]        pix_layer,
    output logic [DATA_W-1:0]         pix_data,
    output logic [9:0]                pix_x,
    output logic [9:0]                pix_y,
    output logic                      collision,
    output logic                      frame_start
);

    localparam int PIPE_W = 1 + LAYER_W + 20;

    logic [PRIO_MAX_W-1:0] w_req_ext;
    int unsigned           w_grant_p0;
    logic                  w_vld_p0;
    logic [LAYER_W-1:0]    w_layer_p0;
    logic [ADDR_W-1:0]     w_addr_p0;
    logic                  w_sof_p0;
    logic                  w_term_p0;
    logic [PIPE_W-1:0]     w_pipe_p0;
    logic [PIPE_W-1:0]     w_pipe_pl;
    logic                  w_vld_pl;
    logic [LAYER_W-1:0]    w_layer_pl;
    logic [9:0]            w_x_pl;
    logic [9:0]            w_y_pl;
    coll_state_t           r_state;
    logic                  r_hit;

    // Keyed builds hide transparent ROM codes; otherwise every granted pixel is shown
    function automatic logic key_pass(input logic [DATA_W-1:0] d);
`ifdef SPRITE_ARB_KEY_EN
        return d != TRANSP;
`else
        return 1'b1;
`endif
    endfunction

    // ---- stage 0: priority grant, address select, frame/overlap detect ----
    assign w_req_ext  = PRIO_MAX_W'(req_on);
    assign w_grant_p0 = prio_enc(w_req_ext);
    assign w_vld_p0   = |req_on;
    assign w_layer_p0 = LAYER_W'(w_grant_p0);
    assign w_sof_p0   = (DrawX == 10'd0) && (DrawY == 10'd0);
    assign w_pipe_p0  = {w_vld_p0, w_layer_p0, DrawX, DrawY};

    generate
        if (NUM_REQ > 1) begin : g_overlap
            assign w_term_p0 = req_on[0] & (|req_on[NUM_REQ-1:1]);
        end else begin : g_no_overlap
            assign w_term_p0 = 1'b0;
        end
    endgenerate

    // Select the granted requester's address
    always_comb begin
        w_addr_p0 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_p0 == unsigned'(i)) w_addr_p0 = req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // ---- stage 1: ROM address register (holds when nobody requests) ----
    always_ff @(posedge frame_Clk) begin
        if (Reset) rom_addr <= '0;
        else if (w_vld_p0) rom_addr <= w_addr_p0;
    end

    // ---- stages 1..ROM_LAT: side-band alignment with the ROM read ----
    sprite_pipe_delay #(
        .DEPTH (ROM_LAT),
        .WIDTH (PIPE_W)
    ) u_align (
        .frame_Clk (frame_Clk),
        .Reset     (Reset),
        .i_d       (w_pipe_p0),
        .o_q       (w_pipe_pl)
    );

    assign w_vld_pl   = w_pipe_pl[PIPE_W-1];
    assign w_layer_pl = w_pipe_pl[PIPE_W-2 -: LAYER_W];
    assign w_x_pl     = w_pipe_pl[19:10];
    assign w_y_pl     = w_pipe_pl[9:0];

    // ---- stage ROM_LAT+1: capture ROM data with its aligned tag ----
    always_ff @(posedge frame_Clk) begin
        if (Reset) begin
            pix_valid <= 1'b0;
            pix_layer <= '0;
            pix_data  <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
        end else begin
            pix_valid <= w_vld_pl & key_pass(rom_data);
            pix_layer <= w_layer_pl;
            pix_data  <= rom_data;
            pix_x     <= w_x_pl;
            pix_y     <= w_y_pl;
        end
    end

    // Registered frame-start pulse, one cycle after pixel (0,0) is presented
    always_ff @(posedge frame_Clk) begin
        if (Reset) frame_start <= 1'b0;
        else frame_start <= w_sof_p0;
    end

    // Collision FSM: accumulate overlap during a frame, publish it at the next frame start
    always_ff @(posedge frame_Clk) begin
        if (Reset) begin
            r_state   <= RUN;
            r_hit     <= 1'b0;
            collision <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_sof_p0) begin
                        collision <= r_hit | w_term_p0;
                        r_hit     <= 1'b0;
                        r_state   <= LATCH;
                    end else begin
                        r_hit <= r_hit | w_term_p0;
                    end
                end
                LATCH: begin
                    r_hit   <= r_hit | w_term_p0;
                    r_state <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

endmodule
